// File: rtl/dispatch_queue.sv
// In-order dual-issue dispatch queue between the dual decoder and execution.
// Circular entry buffer plus a register-busy scoreboard gating RAW/WAW hazards.
module dispatch_queue #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned REG_W = 4,
   parameter int unsigned IMM_W = 5,
   parameter int unsigned OP_W  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid_1,
   input  logic                     in_valid_2,
   input  logic [OP_W-1:0]          in_op_1,
   input  logic [OP_W-1:0]          in_op_2,
   input  logic [REG_W-1:0]         in_des_1,
   input  logic [REG_W-1:0]         in_des_2,
   input  logic [REG_W-1:0]         in_s1_1,
   input  logic [REG_W-1:0]         in_s1_2,
   input  logic [REG_W-1:0]         in_s2_1,
   input  logic [REG_W-1:0]         in_s2_2,
   input  logic [IMM_W-1:0]         in_ime_1,
   input  logic [IMM_W-1:0]         in_ime_2,
   output logic                     in_ready,
   output logic                     out_valid_1,
   output logic                     out_valid_2,
   output logic [OP_W-1:0]          out_op_1,
   output logic [OP_W-1:0]          out_op_2,
   output logic [REG_W-1:0]         out_des_1,
   output logic [REG_W-1:0]         out_des_2,
   output logic [REG_W-1:0]         out_s1_1,
   output logic [REG_W-1:0]         out_s1_2,
   output logic [REG_W-1:0]         out_s2_1,
   output logic [REG_W-1:0]         out_s2_2,
   output logic [IMM_W-1:0]         out_ime_1,
   output logic [IMM_W-1:0]         out_ime_2,
   input  logic                     out_ready_1,
   input  logic                     out_ready_2,
   input  logic                     wb_valid,
   input  logic [REG_W-1:0]         wb_reg,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned NREG  = 2 ** REG_W;

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [REG_W-1:0] des;
      logic [REG_W-1:0] s1;
      logic [REG_W-1:0] s2;
      logic [IMM_W-1:0] ime;
   } entry_t;

   entry_t            q [DEPTH];
   logic [PTR_W-1:0]  head, tail, head_nx, tail_nx;
   logic [CNT_W-1:0]  count_q;
   logic [NREG-1:0]   busy, busy_d;
   entry_t            e1, e2, in_e1, in_e2;
   logic              haz_1, haz_2, pair_hit;
   logic              fire_1, fire_2, enq_1, enq_2;
   logic [1:0]        n_fire, n_enq;

   function automatic logic busy_hit(input logic [REG_W-1:0] r, input logic [NREG-1:0] b);
      return (r != '0) && b[r];
   endfunction

   // add and load are the only ops that produce a register result
   function automatic logic sets_busy(input entry_t e);
      return (e.op[OP_W-1] || e.op[OP_W-2]) && (e.des != '0);
   endfunction

   assign head_nx = head + PTR_W'(1);
   assign tail_nx = tail + PTR_W'(1);
   assign e1      = q[head];
   assign e2      = q[head_nx];
   assign in_e1   = '{op: in_op_1, des: in_des_1, s1: in_s1_1, s2: in_s2_1, ime: in_ime_1};
   assign in_e2   = '{op: in_op_2, des: in_des_2, s1: in_s1_2, s2: in_s2_2, ime: in_ime_2};

   // Issue eligibility depends only on registered state
   always_comb begin
      haz_1       = busy_hit(e1.s1, busy) || busy_hit(e1.s2, busy) || busy_hit(e1.des, busy);
      haz_2       = busy_hit(e2.s1, busy) || busy_hit(e2.s2, busy) || busy_hit(e2.des, busy);
      pair_hit    = (e1.des != '0) &&
                    ((e2.s1 == e1.des) || (e2.s2 == e1.des) || (e2.des == e1.des));
      in_ready    = (count_q <= CNT_W'(DEPTH - 2));
      out_valid_1 = (count_q != '0) && !haz_1;
      out_valid_2 = (count_q >= CNT_W'(2)) && out_valid_1 && !e1.op[0] && !haz_2 && !pair_hit;
   end

   always_comb begin
      fire_1 = out_valid_1 && out_ready_1 && !flush;
      fire_2 = fire_1 && out_valid_2 && out_ready_2;
      enq_1  = in_ready && in_valid_1 && !flush;
      enq_2  = enq_1 && in_valid_2;
      n_fire = {1'b0, fire_1} + {1'b0, fire_2};
      n_enq  = {1'b0, enq_1} + {1'b0, enq_2};
   end

   // Writeback clear first so a same-cycle issue set wins
   always_comb begin
      busy_d = busy;
      if (wb_valid)
         busy_d[wb_reg] = 1'b0;
      if (fire_1 && sets_busy(e1))
         busy_d[e1.des] = 1'b1;
      if (fire_2 && sets_busy(e2))
         busy_d[e2.des] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
         busy    <= '0;
      end else begin
         busy <= busy_d;
         if (flush) begin
            head    <= tail;
            count_q <= '0;
         end else begin
            head    <= head + PTR_W'(n_fire);
            tail    <= tail + PTR_W'(n_enq);
            count_q <= count_q + CNT_W'(n_enq) - CNT_W'(n_fire);
         end
      end
   end

   // Entry payload needs no reset; validity is tracked by count
   always_ff @(posedge clk) begin
      if (enq_1)
         q[tail] <= in_e1;
      if (enq_2)
         q[tail_nx] <= in_e2;
   end

   assign count     = count_q;
   assign out_op_1  = e1.op;
   assign out_des_1 = e1.des;
   assign out_s1_1  = e1.s1;
   assign out_s2_1  = e1.s2;
   assign out_ime_1 = e1.ime;
   assign out_op_2  = e2.op;
   assign out_des_2 = e2.des;
   assign out_s1_2  = e2.s1;
   assign out_s2_2  = e2.s2;
   assign out_ime_2 = e2.ime;

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed self-checking bench for dispatch_queue with hand-computed expectations.
module tb_dispatch_queue;

   localparam logic [3:0] ADD = 4'b1000;
   localparam logic [3:0] LD  = 4'b0100;
   localparam logic [3:0] ST  = 4'b0010;
   localparam logic [3:0] BR  = 4'b0001;

   logic       clk, rst_n;
   logic       in_valid_1, in_valid_2;
   logic [3:0] in_op_1, in_op_2, in_des_1, in_des_2;
   logic [3:0] in_s1_1, in_s1_2, in_s2_1, in_s2_2;
   logic [4:0] in_ime_1, in_ime_2;
   logic       in_ready, out_valid_1, out_valid_2;
   logic [3:0] out_op_1, out_op_2, out_des_1, out_des_2;
   logic [3:0] out_s1_1, out_s1_2, out_s2_1, out_s2_2;
   logic [4:0] out_ime_1, out_ime_2;
   logic       out_ready_1, out_ready_2, wb_valid, flush;
   logic [3:0] wb_reg;
   logic [3:0] count;

   int errors = 0;
   int checks = 0;

   dispatch_queue dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
      .in_op_1(in_op_1), .in_op_2(in_op_2),
      .in_des_1(in_des_1), .in_des_2(in_des_2),
      .in_s1_1(in_s1_1), .in_s1_2(in_s1_2),
      .in_s2_1(in_s2_1), .in_s2_2(in_s2_2),
      .in_ime_1(in_ime_1), .in_ime_2(in_ime_2),
      .in_ready(in_ready),
      .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
      .out_op_1(out_op_1), .out_op_2(out_op_2),
      .out_des_1(out_des_1), .out_des_2(out_des_2),
      .out_s1_1(out_s1_1), .out_s1_2(out_s1_2),
      .out_s2_1(out_s2_1), .out_s2_2(out_s2_2),
      .out_ime_1(out_ime_1), .out_ime_2(out_ime_2),
      .out_ready_1(out_ready_1), .out_ready_2(out_ready_2),
      .wb_valid(wb_valid), .wb_reg(wb_reg),
      .flush(flush), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid_1 = 1'b0;
      in_valid_2 = 1'b0;
   endtask

   task automatic put(input int slot, input logic [3:0] op, input logic [3:0] des,
                      input logic [3:0] s1, input logic [3:0] s2, input logic [4:0] ime);
      if (slot == 1) begin
         in_valid_1 = 1'b1; in_op_1 = op; in_des_1 = des;
         in_s1_1 = s1; in_s2_1 = s2; in_ime_1 = ime;
      end else begin
         in_valid_2 = 1'b1; in_op_2 = op; in_des_2 = des;
         in_s1_2 = s1; in_s2_2 = s2; in_ime_2 = ime;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      in_op_1 = '0; in_op_2 = '0; in_des_1 = '0; in_des_2 = '0;
      in_s1_1 = '0; in_s1_2 = '0; in_s2_1 = '0; in_s2_2 = '0;
      in_ime_1 = '0; in_ime_2 = '0;
      out_ready_1 = 1'b0; out_ready_2 = 1'b0;
      wb_valid = 1'b0; wb_reg = '0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      // 1: independent pair dual-issues, destinations become busy
      do_reset();
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_count", 32'(count), 0);
      check("rst_ov1", 32'(out_valid_1), 0);
      check("rst_ov2", 32'(out_valid_2), 0);
      out_ready_1 = 1'b1; out_ready_2 = 1'b1;
      put(1, ADD, 1, 2, 3, 0); put(2, ADD, 4, 5, 6, 1);
      tick(); idle();
      check("t1_count2", 32'(count), 2);
      check("t1_ov1", 32'(out_valid_1), 1);
      check("t1_ov2", 32'(out_valid_2), 1);
      check("t1_des1", 32'(out_des_1), 1);
      check("t1_des2", 32'(out_des_2), 4);
      tick();
      check("t1_count0", 32'(count), 0);
      check("t1_empty_ov1", 32'(out_valid_1), 0);
      out_ready_1 = 1'b0; out_ready_2 = 1'b0;
      put(1, ADD, 8, 1, 0, 0);
      tick(); idle();
      check("t1_r1_busy", 32'(out_valid_1), 0);
      wb_valid = 1'b1; wb_reg = 4'd1;
      tick(); wb_valid = 1'b0;
      check("t1_r1_cleared", 32'(out_valid_1), 1);

      // 2: RAW inside the pair, slot 2 waits for writeback
      do_reset();
      out_ready_1 = 1'b1; out_ready_2 = 1'b1;
      put(1, ADD, 1, 2, 3, 0); put(2, ADD, 5, 1, 4, 1);
      tick(); idle();
      check("t2_ov1", 32'(out_valid_1), 1);
      check("t2_pair_haz", 32'(out_valid_2), 0);
      tick();
      check("t2_count1", 32'(count), 1);
      check("t2_stall", 32'(out_valid_1), 0);
      check("t2_head_des", 32'(out_des_1), 5);
      tick();
      check("t2_still1", 32'(count), 1);
      wb_valid = 1'b1; wb_reg = 4'd1;
      tick(); wb_valid = 1'b0;
      check("t2_after_wb", 32'(out_valid_1), 1);
      tick();
      check("t2_drained", 32'(count), 0);

      // 3: fill, full back-pressure, wrap of pointers
      do_reset();
      for (int i = 0; i < 3; i++) begin
         put(1, ST, 0, 0, 0, 5'(2 * i)); put(2, ST, 0, 0, 0, 5'(2 * i + 1));
         tick(); idle();
      end
      check("t3_count6", 32'(count), 6);
      check("t3_ready6", 32'(in_ready), 1);
      out_ready_1 = 1'b1; out_ready_2 = 1'b1;
      put(1, ST, 0, 0, 0, 6); put(2, ST, 0, 0, 0, 7);
      tick(); idle();
      check("t3_enq2_fire2", 32'(count), 6);
      out_ready_1 = 1'b0; out_ready_2 = 1'b0;
      put(1, ST, 0, 0, 0, 8);
      tick(); idle();
      check("t3_count7", 32'(count), 7);
      check("t3_full", 32'(in_ready), 0);
      check("t3_head_ime", 32'(out_ime_1), 2);
      out_ready_2 = 1'b1;
      put(1, ST, 0, 0, 0, 20); put(2, ST, 0, 0, 0, 21);
      tick(); idle();
      check("t3_ignored", 32'(count), 7);
      out_ready_1 = 1'b1; out_ready_2 = 1'b0;
      tick();
      check("t3_single", 32'(count), 6);
      check("t3_ready_back", 32'(in_ready), 1);
      check("t3_ime3", 32'(out_ime_1), 3);
      out_ready_2 = 1'b1;
      tick();
      check("t3_count4", 32'(count), 4);
      check("t3_ime5", 32'(out_ime_1), 5);
      tick();
      check("t3_count2", 32'(count), 2);
      check("t3_ime7", 32'(out_ime_1), 7);
      check("t3_wrap_ime8", 32'(out_ime_2), 8);
      tick();
      check("t3_count0", 32'(count), 0);
      check("t3_ov1", 32'(out_valid_1), 0);

      // 4: branch in slot 1 blocks slot 2
      do_reset();
      put(1, BR, 0, 0, 0, 9); put(2, ST, 0, 0, 0, 10);
      tick(); idle();
      check("t4_ov1", 32'(out_valid_1), 1);
      check("t4_br_blocks", 32'(out_valid_2), 0);
      check("t4_op_br", 32'(out_op_1), 32'(BR));
      out_ready_1 = 1'b1; out_ready_2 = 1'b1;
      tick();
      check("t4_count1", 32'(count), 1);
      check("t4_op_st", 32'(out_op_1), 32'(ST));
      tick();
      check("t4_count0", 32'(count), 0);

      // 5: load issue and writeback of the same register, set wins
      do_reset();
      put(1, LD, 2, 0, 0, 3);
      tick(); idle();
      out_ready_1 = 1'b1; wb_valid = 1'b1; wb_reg = 4'd2;
      tick();
      wb_valid = 1'b0; out_ready_1 = 1'b0;
      put(1, ADD, 3, 2, 0, 0);
      tick(); idle();
      check("t5_set_wins", 32'(out_valid_1), 0);
      wb_valid = 1'b1; wb_reg = 4'd2;
      tick(); wb_valid = 1'b0;
      check("t5_cleared", 32'(out_valid_1), 1);

      // 6: flush keeps scoreboard, then mid-run async reset
      do_reset();
      out_ready_1 = 1'b1;
      put(1, ADD, 1, 0, 0, 0);
      tick(); idle();
      tick();
      check("t6_issued", 32'(count), 0);
      out_ready_1 = 1'b0;
      put(1, ST, 0, 0, 0, 1); put(2, ST, 0, 0, 0, 2);
      tick();
      tick(); idle();
      put(1, ST, 0, 0, 0, 5);
      tick(); idle();
      check("t6_count5", 32'(count), 5);
      flush = 1'b1; out_ready_1 = 1'b1; out_ready_2 = 1'b1;
      put(1, ST, 0, 0, 0, 6); put(2, ST, 0, 0, 0, 7);
      tick();
      flush = 1'b0; idle(); out_ready_1 = 1'b0; out_ready_2 = 1'b0;
      check("t6_flush_count", 32'(count), 0);
      check("t6_flush_ov1", 32'(out_valid_1), 0);
      check("t6_flush_ready", 32'(in_ready), 1);
      put(1, ADD, 4, 1, 0, 0);
      tick(); idle();
      check("t6_busy_kept", 32'(out_valid_1), 0);
      check("t6_pre_rst_count", 32'(count), 1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_count", 32'(count), 0);
      check("t6_rst_ov1", 32'(out_valid_1), 0);
      check("t6_rst_ready", 32'(in_ready), 1);
      #2 rst_n = 1'b1;
      put(1, ADD, 5, 1, 0, 0);
      tick(); idle();
      check("t6_busy_reset", 32'(out_valid_1), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- In-order dispatch buffer sitting directly downstream of the dual instruction decoder.
- Accepts up to two decoded instructions per cycle (one-hot op, des, s1, s2, ime) into a circular queue.
- Issues up to two per cycle, oldest first, to the execution-side consumer.
- A register-busy scoreboard holds back RAW and WAW hazards until writeback clears them.

Parameters:
DEPTH, 8, queue entries; power of two, minimum 4
REG_W, 4, register index width
IMM_W, 5, immediate width
OP_W, 4, one-hot op width: 1000 add, 0100 load, 0010 store, 0001 branch

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid_1  in  1  decoded instruction 1 present
in_valid_2  in  1  decoded instruction 2 present; only legal with in_valid_1=1
in_op_1/in_op_2  in  OP_W  one-hot op
in_des_1/in_des_2  in  REG_W  destination; 0 = none
in_s1_1/in_s1_2, in_s2_1/in_s2_2  in  REG_W  sources; 0 = unused
in_ime_1/in_ime_2  in  IMM_W  immediate
in_ready  out  1  queue can accept a pair this cycle
out_valid_1/out_valid_2  out  1  issue slot holds an issuable instruction
out_op_k, out_des_k, out_s1_k, out_s2_k, out_ime_k  out  per field  issue slot k fields, k=1,2
out_ready_1/out_ready_2  in  1  consumer accepts slot k
wb_valid  in  1  writeback completes
wb_reg  in  REG_W  register whose busy bit clears
flush  in  1  discard all queued entries
count  out  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, rst_n=0): head=tail=0, count=0, all busy bits 0, out_valid_1/2=0, in_ready=1. Data outputs reflect the head entry and need not be zero.
- Enqueue:
  - in_ready = (DEPTH - count >= 2), registered-state based only; no combinational dependence on this cycle's dequeue.
  - When in_ready=1, in_valid_1 writes entry tail; in_valid_2 additionally writes tail+1.
  - Pointers wrap modulo DEPTH.
  - Inputs while in_ready=0 are ignored; the upstream stage holds them.
  - in_valid_2 without in_valid_1: both ignored.
- Issue slot 1 = head entry. out_valid_1 = count>=1 AND no hazard. Hazard means:
  - s1 nonzero and busy, OR
  - s2 nonzero and busy, OR
  - des nonzero and busy (WAW).
- Issue slot 2 = head+1. out_valid_2 = count>=2 AND out_valid_1 AND slot-1 op is not branch AND own scoreboard check clean AND no intra-pair hazard. Intra-pair hazard: slot-2 s1/s2/des equals slot-1 des, with slot-1 des nonzero.
- Fire rules:
  - Slot k fires when out_valid_k and out_ready_k.
  - Slot 2 may fire only if slot 1 fires the same cycle; out_ready_2 with slot 1 not firing → slot 2 does not fire.
  - Head advances by the number fired (0/1/2).
  - count updates by enqueued minus fired in the same cycle.
- Scoreboard:
  - On fire, busy[des] <= 1 for add/load with des nonzero.
  - wb_valid clears busy[wb_reg] at the clock edge; no same-cycle bypass into the hazard check.
  - Same-cycle set and clear of the same register: set wins.
  - Register 0 is never busy.
- Flush:
  - Queue empties next cycle (head=tail, count=0).
  - Simultaneous enqueue and issue are discarded.
  - Scoreboard is untouched, because already-issued instructions still write back.
  - Flush dominates everything except reset.
- Full/empty:
  - count=DEPTH-1 → in_ready=0.
  - count=0 → out_valid_1=0.
  - Simultaneous enqueue of 2 and issue of 2 at count=DEPTH-2 keeps count unchanged.

Test Plan:
1. Reset, enqueue pair add r1←r2+r3, add r4←r5+r6; out_ready_1/2=1 → both issue next cycle; busy r1, r4 set; count 2→0.
2. Pair add r1←r2+r3, add r5←r1+r4 → slot 1 issues alone; slot 2 then stalls (r1 busy) until wb_valid, wb_reg=1; issues the cycle after wb.
3. Fill to 7 entries with out_ready=0 → in_ready=0, new pair ignored, count stays 7; release out_ready → count drains, in_ready returns when count<=6; pointers wrap correctly across index 7→0.
4. Branch at head followed by store → branch issues alone in slot 1; store issues the next cycle in slot 1.
5. Load r2 with wb_valid wb_reg=2 arriving while busy[2]=0 and load issuing the same cycle → busy[2]=1 (set wins).
6. Queue holding 5 entries, flush asserted together with enqueue of a pair → next cycle count=0, out_valid_1=0, busy bits unchanged; assert rst_n=0 mid-operation → all outputs return to reset values immediately.
